// File: rtl/cdc_pkg.sv
// Shared constants and sizing helpers for the CDC synchroniser blocks.
package cdc_pkg;

    localparam int CDC_MIN_STAGES = 2;
    localparam int CDC_MAX_FILTER = 255;

    // Counter width able to hold 0..filter; every CDC block sizes its filter counter this way.
    function automatic int cnt_width(input int filter);
        return (filter < 1) ? 1 : $clog2(filter + 1);
    endfunction

endpackage

// File: rtl/sync_nff_filt_if.sv
// Bundle of asynchronous inputs and synchronised, filtered outputs for sync_nff_filt.
interface sync_nff_filt_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_rise;
    logic [WIDTH-1:0] q_fall;
    logic [WIDTH-1:0] stable;

    modport master (
        output d,
        input  q,
        input  q_rise,
        input  q_fall,
        input  stable
    );

    modport slave (
        input  d,
        output q,
        output q_rise,
        output q_fall,
        output stable
    );

endinterface

// File: rtl/sync_nff_chan.sv
// One synchroniser channel: flop chain, glitch-filter counter, filtered level and edge pulses.
module sync_nff_chan
    import cdc_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter int   FILTER  = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_ff,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic q_rise,
    output logic q_fall,
    output logic stable
);

    localparam int            CW  = cnt_width(FILTER);
    localparam logic [CW-1:0] LIM = CW'(FILTER - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] st_q;
    logic [STAGES-1:0] st_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              q_q, q_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              s;

    assign s = st_q[STAGES-1];

    always_comb begin
        st_d   = {st_q[STAGES-2:0], d};
        cnt_d  = '0;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // A new level must be seen FILTER consecutive cycles; any return to q clears the count.
        if (s != q_q) begin
            if (cnt_q == LIM) begin
                q_d    = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_ff) begin
        if (rst) begin
            st_q   <= {STAGES{RST_VAL}};
            cnt_q  <= '0;
            q_q    <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q      = q_q;
    assign q_rise = rise_q;
    assign q_fall = fall_q;
    assign stable = (s == q_q) && (cnt_q == '0);

endmodule

// File: rtl/sync_nff_filt.sv
// Bank of WIDTH independent filtered synchronisers bringing async inputs into the clk_ff domain.
module sync_nff_filt
    import cdc_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter int               FILTER  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic            clk_ff,
    input  logic            rst,
    sync_nff_filt_if.slave  bus
);

    if (WIDTH < 1) begin : g_chk_width
        $error("sync_nff_filt: WIDTH must be >= 1");
    end
    if (STAGES < CDC_MIN_STAGES) begin : g_chk_stages
        $error("sync_nff_filt: STAGES below minimum synchroniser depth");
    end
    if (FILTER < 1 || FILTER > CDC_MAX_FILTER) begin : g_chk_filter
        $error("sync_nff_filt: FILTER out of range");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_nff_chan #(
            .STAGES  (STAGES),
            .FILTER  (FILTER),
            .RST_VAL (RST_VAL[i])
        ) u_chan (
            .clk_ff (clk_ff),
            .rst    (rst),
            .d      (bus.d[i]),
            .q      (bus.q[i]),
            .q_rise (bus.q_rise[i]),
            .q_fall (bus.q_fall[i]),
            .stable (bus.stable[i])
        );
    end

endmodule

// File: tb/tb_sync_nff_filt.sv
// Directed bench: one bank at STAGES=2/FILTER=3/RST_VAL=0 and one at STAGES=3/FILTER=1/RST_VAL=F.
module tb_sync_nff_filt;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   total;
    int   bad;

    sync_nff_filt_if #(.WIDTH(4)) ia ();
    sync_nff_filt_if #(.WIDTH(4)) ib ();

    sync_nff_filt #(
        .WIDTH   (4),
        .STAGES  (2),
        .FILTER  (3),
        .RST_VAL (4'b0000)
    ) u_a (
        .clk_ff (clk),
        .rst    (rst_a),
        .bus    (ia)
    );

    sync_nff_filt #(
        .WIDTH   (4),
        .STAGES  (3),
        .FILTER  (1),
        .RST_VAL (4'hF)
    ) u_b (
        .clk_ff (clk),
        .rst    (rst_b),
        .bus    (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] eq, input logic [3:0] er,
                         input logic [3:0] ef);
        chk({tag, ".q"},    ia.q,      eq);
        chk({tag, ".rise"}, ia.q_rise, er);
        chk({tag, ".fall"}, ia.q_fall, ef);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.d  = 4'b0000;
        ib.d  = 4'hF;

        // Test 1 / test 6 reset part: hold reset, then release.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("t1_rst", 4'b0000, 4'b0000, 4'b0000);
            chk("t1_rst.stable", ia.stable, 4'hF);
            chk("t6_rst.q",      ib.q,      4'hF);
            chk("t6_rst.fall",   ib.q_fall, 4'h0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_a("t1_run", 4'b0000, 4'b0000, 4'b0000);
            chk("t1_run.stable", ia.stable, 4'hF);
            chk("t6_run.q",      ib.q,      4'hF);
            chk("t6_run.fall",   ib.q_fall, 4'h0);
            chk("t6_run.rise",   ib.q_rise, 4'h0);
        end

        // Test 2: d[0] rises, sampled at edge k; q follows after edge k+4.
        ia.d = 4'b0001;
        step();
        chk_a("t2_k0", 4'b0000, 4'b0000, 4'b0000);
        step();
        chk_a("t2_k1", 4'b0000, 4'b0000, 4'b0000);
        step();
        chk_a("t2_k2", 4'b0000, 4'b0000, 4'b0000);
        chk("t2_k2.stable", ia.stable, 4'b1110);
        step();
        chk_a("t2_k3", 4'b0000, 4'b0000, 4'b0000);
        chk("t2_k3.stable", ia.stable, 4'b1110);
        step();
        chk_a("t2_k4", 4'b0001, 4'b0001, 4'b0000);
        chk("t2_k4.stable", ia.stable, 4'hF);
        step();
        chk_a("t2_k5", 4'b0001, 4'b0000, 4'b0000);

        // Test 3a: 2-cycle pulse on d[1] is filtered out.
        ia.d = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 1) ia.d = 4'b0001;
            chk_a("t3_short", 4'b0001, 4'b0000, 4'b0000);
        end
        chk("t3_short.stable", ia.stable, 4'hF);

        // Test 3b: 3-cycle pulse propagates: rise after edge j+4, fall after j+7.
        ia.d = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) ia.d = 4'b0001;
            chk_a("t3_long",
                  (i >= 4 && i < 7) ? 4'b0011 : 4'b0001,
                  (i == 4) ? 4'b0010 : 4'b0000,
                  (i == 7) ? 4'b0010 : 4'b0000);
        end

        // Settle bit 0 back to 0 (fall after 4 edges).
        ia.d = 4'b0000;
        for (int i = 0; i < 6; i++) step();
        chk_a("t4_pre", 4'b0000, 4'b0000, 4'b0000);

        // Test 4: simultaneous changes on bits 3 and 1.
        ia.d = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_a("t4_up",
                  (i >= 4) ? 4'b1010 : 4'b0000,
                  (i == 4) ? 4'b1010 : 4'b0000,
                  4'b0000);
        end
        ia.d = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_a("t4_dn",
                  (i >= 4) ? 4'b0000 : 4'b1010,
                  4'b0000,
                  (i == 4) ? 4'b1010 : 4'b0000);
        end

        // Test 5: reset while bit 2 has a pending rise (cnt=1 after edge k+2).
        ia.d = 4'b0100;
        step();
        step();
        step();
        chk("t5_pend.stable", ia.stable, 4'b1011);
        rst_a = 1'b1;
        step();
        chk_a("t5_rst", 4'b0000, 4'b0000, 4'b0000);
        chk("t5_rst.stable", ia.stable, 4'hF);
        step();
        chk_a("t5_rst2", 4'b0000, 4'b0000, 4'b0000);
        rst_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_a("t5_rel",
                  (i >= 4) ? 4'b0100 : 4'b0000,
                  (i == 4) ? 4'b0100 : 4'b0000,
                  4'b0000);
        end

        // Test 6: FILTER=1, STAGES=3 -> change reaches q 3 edges after sampling.
        ib.d = 4'hE;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_dn.q",    ib.q,      (i >= 3) ? 4'hE : 4'hF);
            chk("t6_dn.fall", ib.q_fall, (i == 3) ? 4'h1 : 4'h0);
        end
        ib.d = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_up.q",    ib.q,      (i >= 3) ? 4'hF : 4'hE);
            chk("t6_up.rise", ib.q_rise, (i == 3) ? 4'h1 : 4'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
